ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single-ported RAM.
// Data wins ties unless an instruction request has waited STARVE_MAX data grants.
module ram_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iren,
  input  logic [31:0] iaddr,
  output logic        ihit,
  output logic [31:0] iload,
  input  logic        dren,
  input  logic        dwen,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic [3:0]  dbyte_en,
  output logic        dhit,
  output logic [31:0] dload,
  output logic [31:0] ram_addr,
  output logic        ram_ren,
  output logic        ram_wen,
  output logic [31:0] ram_store,
  output logic [3:0]  ram_byte_en,
  input  logic [31:0] ram_load,
  input  logic        ram_ready
);

  localparam int unsigned CntW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StIBusy, StDBusy, StResp} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] starve_q, starve_d;
  logic [31:0]     ram_addr_q, ram_addr_d;
  logic            ram_ren_q, ram_ren_d;
  logic            ram_wen_q, ram_wen_d;
  logic [31:0]     ram_store_q, ram_store_d;
  logic [3:0]      ram_byte_en_q, ram_byte_en_d;
  logic            ihit_q, ihit_d;
  logic            dhit_q, dhit_d;
  logic [31:0]     iload_q, iload_d;
  logic [31:0]     dload_q, dload_d;

  logic dreq, grant_i, grant_d;

  assign dreq    = dren | dwen;
  assign grant_i = iren & (~dreq | (starve_q == StarveMax));
  assign grant_d = dreq & ~grant_i;

  always_comb begin
    state_d       = state_q;
    starve_d      = starve_q;
    ram_addr_d    = ram_addr_q;
    ram_ren_d     = ram_ren_q;
    ram_wen_d     = ram_wen_q;
    ram_store_d   = ram_store_q;
    ram_byte_en_d = ram_byte_en_q;
    ihit_d        = 1'b0;
    dhit_d        = 1'b0;
    iload_d       = iload_q;
    dload_d       = dload_q;

    unique case (state_q)
      StIdle: begin
        ram_addr_d    = '0;
        ram_ren_d     = 1'b0;
        ram_wen_d     = 1'b0;
        ram_store_d   = '0;
        ram_byte_en_d = '0;
        if (grant_i) begin
          state_d       = StIBusy;
          starve_d      = '0;
          ram_addr_d    = iaddr;
          ram_ren_d     = 1'b1;
          ram_byte_en_d = 4'hF;
        end else if (grant_d) begin
          state_d    = StDBusy;
          ram_addr_d = daddr;
          // Only grants that actually made an instruction wait count toward starvation.
          if (!iren) begin
            starve_d = '0;
          end else if (starve_q != StarveMax) begin
            starve_d = starve_q + CntW'(1);
          end
          if (dwen) begin
            ram_wen_d     = 1'b1;
            ram_store_d   = dstore;
            ram_byte_en_d = dbyte_en;
          end else begin
            ram_ren_d     = 1'b1;
            ram_byte_en_d = 4'hF;
          end
        end
      end
      StIBusy, StDBusy: begin
        if (ram_ready) begin
          state_d       = StResp;
          ram_addr_d    = '0;
          ram_ren_d     = 1'b0;
          ram_wen_d     = 1'b0;
          ram_store_d   = '0;
          ram_byte_en_d = '0;
          if (state_q == StIBusy) begin
            ihit_d  = 1'b1;
            iload_d = ram_load;
          end else begin
            dhit_d = 1'b1;
            if (ram_ren_q) begin
              dload_d = ram_load;
            end
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      starve_q      <= '0;
      ram_addr_q    <= '0;
      ram_ren_q     <= 1'b0;
      ram_wen_q     <= 1'b0;
      ram_store_q   <= '0;
      ram_byte_en_q <= '0;
      ihit_q        <= 1'b0;
      dhit_q        <= 1'b0;
      iload_q       <= '0;
      dload_q       <= '0;
    end else begin
      state_q       <= state_d;
      starve_q      <= starve_d;
      ram_addr_q    <= ram_addr_d;
      ram_ren_q     <= ram_ren_d;
      ram_wen_q     <= ram_wen_d;
      ram_store_q   <= ram_store_d;
      ram_byte_en_q <= ram_byte_en_d;
      ihit_q        <= ihit_d;
      dhit_q        <= dhit_d;
      iload_q       <= iload_d;
      dload_q       <= dload_d;
    end
  end

  assign ram_addr    = ram_addr_q;
  assign ram_ren     = ram_ren_q;
  assign ram_wen     = ram_wen_q;
  assign ram_store   = ram_store_q;
  assign ram_byte_en = ram_byte_en_q;
  assign ihit        = ihit_q;
  assign dhit        = dhit_q;
  assign iload       = iload_q;
  assign dload       = dload_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: per-cycle vector table plus hand-written
// starvation and mid-access reset sequences.
module tb_ram_arbiter;

  logic        clk;
  logic        rst;
  logic        iren;
  logic [31:0] iaddr;
  logic        ihit;
  logic [31:0] iload;
  logic        dren;
  logic        dwen;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [3:0]  dbyte_en;
  logic        dhit;
  logic [31:0] dload;
  logic [31:0] ram_addr;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_store;
  logic [3:0]  ram_byte_en;
  logic [31:0] ram_load;
  logic        ram_ready;

  int n_cmp = 0;
  int n_bad = 0;

  ram_arbiter #(.STARVE_MAX(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .iren        (iren),
    .iaddr       (iaddr),
    .ihit        (ihit),
    .iload       (iload),
    .dren        (dren),
    .dwen        (dwen),
    .daddr       (daddr),
    .dstore      (dstore),
    .dbyte_en    (dbyte_en),
    .dhit        (dhit),
    .dload       (dload),
    .ram_addr    (ram_addr),
    .ram_ren     (ram_ren),
    .ram_wen     (ram_wen),
    .ram_store   (ram_store),
    .ram_byte_en (ram_byte_en),
    .ram_load    (ram_load),
    .ram_ready   (ram_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs held during the cycle before an edge; expected outputs just after it.
  typedef struct {
    logic        rst;
    logic        iren;
    logic [31:0] iaddr;
    logic        dren;
    logic        dwen;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [3:0]  dbe;
    logic        rdy;
    logic [31:0] rload;
    logic        e_ihit;
    logic        e_dhit;
    logic [31:0] e_iload;
    logic [31:0] e_dload;
    logic [31:0] e_addr;
    logic        e_ren;
    logic        e_wen;
    logic [31:0] e_store;
    logic [3:0]  e_be;
  } vec_t;

  localparam int NVec = 18;
  vec_t vecs[NVec];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ram_idle(input string tag);
    chk({tag, " ram_addr"}, ram_addr, 32'h0);
    chk({tag, " ram_ren"}, {31'h0, ram_ren}, 32'h0);
    chk({tag, " ram_wen"}, {31'h0, ram_wen}, 32'h0);
    chk({tag, " ram_store"}, ram_store, 32'h0);
    chk({tag, " ram_byte_en"}, {28'h0, ram_byte_en}, 32'h0);
  endtask

  task automatic chk_no_overlap(input string tag);
    chk({tag, " ihit&dhit"}, {31'h0, ihit & dhit}, 32'h0);
  endtask

  task automatic drive_idle();
    rst = 1'b0; iren = 1'b0; iaddr = '0; dren = 1'b0; dwen = 1'b0;
    daddr = '0; dstore = '0; dbyte_en = '0; ram_ready = 1'b0; ram_load = '0;
  endtask

  initial begin
    logic [31:0] exp_addr [6];
    logic [31:0] last_dload;
    int          k;
    logic        i_done;
    string       tag;

    // Order: rst iren iaddr dren dwen daddr dstore dbe rdy rload |
    //        ihit dhit iload dload addr ren wen store be
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0,
                 0, 0, 0, 0, 0, 0, 0, 0, 4'h0};
    // Single instruction fetch, minimum latency.
    vecs[1]  = '{0, 1, 32'h100, 0, 0, 0, 0, 4'h0, 0, 0,
                 0, 0, 0, 0, 32'h100, 1, 0, 0, 4'hF};
    vecs[2]  = '{0, 1, 32'h100, 0, 0, 0, 0, 4'h0, 1, 32'h13,
                 1, 0, 32'h13, 0, 0, 0, 0, 0, 4'h0};
    vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0,
                 0, 0, 32'h13, 0, 0, 0, 0, 0, 4'h0};
    // Simultaneous requests: data first, IDLE gap, then instruction.
    vecs[4]  = '{0, 1, 32'h104, 1, 0, 32'h200, 0, 4'h0, 0, 0,
                 0, 0, 32'h13, 0, 32'h200, 1, 0, 0, 4'hF};
    vecs[5]  = '{0, 1, 32'h104, 1, 0, 32'h200, 0, 4'h0, 1, 32'hA5A50001,
                 0, 1, 32'h13, 32'hA5A50001, 0, 0, 0, 0, 4'h0};
    vecs[6]  = '{0, 1, 32'h104, 0, 0, 0, 0, 4'h0, 0, 0,
                 0, 0, 32'h13, 32'hA5A50001, 0, 0, 0, 0, 4'h0};
    vecs[7]  = '{0, 1, 32'h104, 0, 0, 0, 0, 4'h0, 0, 0,
                 0, 0, 32'h13, 32'hA5A50001, 32'h104, 1, 0, 0, 4'hF};
    vecs[8]  = '{0, 1, 32'h104, 0, 0, 0, 0, 4'h0, 1, 32'h93,
                 1, 0, 32'h93, 32'hA5A50001, 0, 0, 0, 0, 4'h0};
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0,
                 0, 0, 32'h93, 32'hA5A50001, 0, 0, 0, 0, 4'h0};
    // Write with ready delayed; later input changes must be ignored.
    vecs[10] = '{0, 0, 0, 0, 1, 32'h300, 32'hDEADBEEF, 4'h3, 0, 0,
                 0, 0, 32'h93, 32'hA5A50001, 32'h300, 0, 1, 32'hDEADBEEF, 4'h3};
    vecs[11] = '{0, 0, 0, 0, 1, 32'h304, 32'h12345678, 4'hC, 0, 0,
                 0, 0, 32'h93, 32'hA5A50001, 32'h300, 0, 1, 32'hDEADBEEF, 4'h3};
    vecs[12] = '{0, 0, 0, 0, 1, 32'h304, 32'h12345678, 4'hC, 0, 0,
                 0, 0, 32'h93, 32'hA5A50001, 32'h300, 0, 1, 32'hDEADBEEF, 4'h3};
    vecs[13] = '{0, 0, 0, 0, 1, 32'h304, 32'h12345678, 4'hC, 1, 32'hFFFFFFFF,
                 0, 1, 32'h93, 32'hA5A50001, 0, 0, 0, 0, 4'h0};
    vecs[14] = '{0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0,
                 0, 0, 32'h93, 32'hA5A50001, 0, 0, 0, 0, 4'h0};
    // dren and dwen together: write only.
    vecs[15] = '{0, 0, 0, 1, 1, 32'h400, 32'h0BADF00D, 4'hC, 0, 0,
                 0, 0, 32'h93, 32'hA5A50001, 32'h400, 0, 1, 32'h0BADF00D, 4'hC};
    vecs[16] = '{0, 0, 0, 1, 1, 32'h400, 32'h0BADF00D, 4'hC, 1, 32'h11111111,
                 0, 1, 32'h93, 32'hA5A50001, 0, 0, 0, 0, 4'h0};
    vecs[17] = '{0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0,
                 0, 0, 32'h93, 32'hA5A50001, 0, 0, 0, 0, 4'h0};

    drive_idle();
    rst = 1'b1;
    step();

    for (int i = 0; i < NVec; i++) begin
      rst = vecs[i].rst; iren = vecs[i].iren; iaddr = vecs[i].iaddr;
      dren = vecs[i].dren; dwen = vecs[i].dwen; daddr = vecs[i].daddr;
      dstore = vecs[i].dstore; dbyte_en = vecs[i].dbe;
      ram_ready = vecs[i].rdy; ram_load = vecs[i].rload;
      step();
      tag = $sformatf("v%0d", i);
      chk({tag, " ihit"}, {31'h0, ihit}, {31'h0, vecs[i].e_ihit});
      chk({tag, " dhit"}, {31'h0, dhit}, {31'h0, vecs[i].e_dhit});
      chk({tag, " iload"}, iload, vecs[i].e_iload);
      chk({tag, " dload"}, dload, vecs[i].e_dload);
      chk({tag, " ram_addr"}, ram_addr, vecs[i].e_addr);
      chk({tag, " ram_ren"}, {31'h0, ram_ren}, {31'h0, vecs[i].e_ren});
      chk({tag, " ram_wen"}, {31'h0, ram_wen}, {31'h0, vecs[i].e_wen});
      chk({tag, " ram_store"}, ram_store, vecs[i].e_store);
      chk({tag, " ram_byte_en"}, {28'h0, ram_byte_en}, {28'h0, vecs[i].e_be});
      chk_no_overlap(tag);
    end

    // Starvation: iren held, five data reads; expect D D D D I D.
    exp_addr[0] = 32'h600; exp_addr[1] = 32'h604; exp_addr[2] = 32'h608;
    exp_addr[3] = 32'h60C; exp_addr[4] = 32'h500; exp_addr[5] = 32'h610;
    k = 0;
    i_done = 1'b0;
    for (int g = 0; g < 6; g++) begin
      tag = $sformatf("starve g%0d", g);
      iren = ~i_done; iaddr = 32'h500;
      dren = (k < 5); daddr = 32'h600 + 32'(4 * k);
      ram_ready = 1'b0;
      step();
      chk({tag, " grant addr"}, ram_addr, exp_addr[g]);
      chk({tag, " ram_ren"}, {31'h0, ram_ren}, 32'h1);
      ram_ready = 1'b1; ram_load = 32'hC0DE0000 + 32'(g);
      step();
      ram_ready = 1'b0;
      if (g == 4) begin
        chk({tag, " ihit"}, {31'h0, ihit}, 32'h1);
        chk({tag, " iload"}, iload, 32'hC0DE0004);
        i_done = 1'b1;
      end else begin
        chk({tag, " dhit"}, {31'h0, dhit}, 32'h1);
        chk({tag, " dload"}, dload, 32'hC0DE0000 + 32'(g));
        k++;
      end
      chk_no_overlap(tag);
      iren = ~i_done;
      dren = (k < 5); daddr = 32'h600 + 32'(4 * k);
      step();
      chk_ram_idle({tag, " resp->idle"});
    end
    last_dload = dload;
    chk("starve final dload", last_dload, 32'hC0DE0005);

    // Reset while a data read is in flight; ram_ready at the reset edge must be ignored.
    drive_idle();
    dren = 1'b1; daddr = 32'h700;
    step();
    chk("rst-seq busy ram_ren", {31'h0, ram_ren}, 32'h1);
    chk("rst-seq busy ram_addr", ram_addr, 32'h700);
    step();
    rst = 1'b1; ram_ready = 1'b1; ram_load = 32'hBAD0BAD0;
    step();
    chk_ram_idle("rst-seq after rst");
    chk("rst-seq dhit", {31'h0, dhit}, 32'h0);
    chk("rst-seq ihit", {31'h0, ihit}, 32'h0);
    chk("rst-seq dload cleared", dload, 32'h0);
    chk("rst-seq iload cleared", iload, 32'h0);
    rst = 1'b0; ram_ready = 1'b0;
    step();
    chk("rst-seq regrant dhit", {31'h0, dhit}, 32'h0);
    chk("rst-seq regrant ram_ren", {31'h0, ram_ren}, 32'h1);
    chk("rst-seq regrant ram_addr", ram_addr, 32'h700);
    ram_ready = 1'b1; ram_load = 32'h00000077;
    step();
    chk("rst-seq dhit", {31'h0, dhit}, 32'h1);
    chk("rst-seq dload", dload, 32'h00000077);
    drive_idle();
    step();
    chk("rst-seq dhit one cycle", {31'h0, dhit}, 32'h0);
    chk_ram_idle("rst-seq end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
